// File: rtl/spi_cmd_dispatch_if.sv
// Byte-level SPI link between the SPI slave front end and the command
// dispatcher.
//   SSEL               : chip select, active low, synchronous to CLK
//   byte_received      : one-CLK strobe, byte_data_received is valid
//   byte_data_received : received byte
//   spi_send_data      : byte shifted out on MISO during the next SPI byte
//   word_received      : one-CLK strobe, a full word was assembled
//   word_data_received : last assembled little-endian word
interface spi_cmd_dispatch_if #(
    parameter int WORD_BYTES = 4
);
    logic                    SSEL;
    logic                    byte_received;
    logic [7:0]              byte_data_received;
    logic [7:0]              spi_send_data;
    logic                    word_received;
    logic [8*WORD_BYTES-1:0] word_data_received;

    modport slave (
        input  SSEL, byte_received, byte_data_received,
        output spi_send_data, word_received, word_data_received
    );

    modport master (
        output SSEL, byte_received, byte_data_received,
        input  spi_send_data, word_received, word_data_received
    );
endinterface

// File: rtl/spi_cmd_dispatch.sv
// SPI command dispatcher for a bank of stepper channels.
// Assembles received bytes into little-endian words, decodes header words
// (opcode, channel, control bits) and executes NOP / WRITE_PERIOD /
// SET_CTRL / READ_PERIOD / CLEAR_ERR.
//   CLK, resetn  : system clock, asynchronous active-low reset
//   spi          : byte link (see spi_cmd_dispatch_if), slave side
//   enable       : per-channel driver enable
//   direction    : per-channel step direction
//   step_period  : per-channel period, channel n at [n*W +: W]
//   err          : sticky command error flag
module spi_cmd_dispatch #(
    parameter int NUM_CHANNELS = 4,
    parameter int WORD_BYTES   = 4
) (
    input  logic                              CLK,
    input  logic                              resetn,
    spi_cmd_dispatch_if.slave                 spi,
    output logic [NUM_CHANNELS-1:0]           enable,
    output logic [NUM_CHANNELS-1:0]           direction,
    output logic [NUM_CHANNELS*8*WORD_BYTES-1:0] step_period,
    output logic                              err
);
    localparam int W = 8 * WORD_BYTES;
    localparam logic [7:0] NCH  = 8'(NUM_CHANNELS);
    localparam logic [2:0] LAST = 3'(WORD_BYTES - 1);

    typedef enum logic [1:0] {
        HEADER     = 2'd0,
        WR_PAYLOAD = 2'd1,
        RD_PAYLOAD = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [2:0]                 cnt_q, cnt_d;
    logic [W-1:0]               buf_q, buf_d;
    logic [3:0]                 ch_q, ch_d;
    logic                       ch_ok_q, ch_ok_d;
    logic                       err_q, err_d;
    logic [NUM_CHANNELS-1:0]    en_q, en_d;
    logic [NUM_CHANNELS-1:0]    dir_q, dir_d;
    logic [NUM_CHANNELS*W-1:0]  per_q, per_d;
    logic [7:0]                 send_q, send_d;
    logic                       wrx_q, wrx_d;
    logic [W-1:0]               word_q, word_d;

    logic                       last;
    logic [W-1:0]               word_asm;
    logic [7:0]                 opcode;
    logic [7:0]                 ch_byte;
    logic [1:0]                 ctrl;
    logic                       ch_valid;
    logic [W-1:0]               rd_word;
    logic [7:0]                 rd_byte;

    assign last = (cnt_q == LAST);

    // Current partial word with the incoming byte merged in at its slot.
    always_comb begin
        word_asm = buf_q;
        for (int unsigned k = 0; k < WORD_BYTES; k++) begin
            if (cnt_q == 3'(k)) begin
                word_asm[k*8 +: 8] = spi.byte_data_received;
            end
        end
    end

    assign opcode   = word_asm[7:0];
    assign ch_byte  = word_asm[15:8];
    assign ch_valid = (ch_byte < NCH);

    // Two-byte words carry no control byte.
    if (WORD_BYTES > 2) begin : g_ctrl
        assign ctrl = word_asm[17:16];
    end else begin : g_no_ctrl
        assign ctrl = '0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        ch_d    = ch_q;
        ch_ok_d = ch_ok_q;
        err_d   = err_q;
        en_d    = en_q;
        dir_d   = dir_q;
        per_d   = per_q;
        send_d  = send_q;
        wrx_d   = 1'b0;
        word_d  = word_q;
        rd_word = '0;
        rd_byte = '0;

        if (spi.SSEL) begin
            // Deselect abandons any partial word or pending payload.
            state_d = HEADER;
            cnt_d   = '0;
            buf_d   = '0;
        end else if (spi.byte_received) begin
            buf_d = word_asm;
            cnt_d = last ? 3'd0 : cnt_q + 3'd1;
            if (last) begin
                buf_d  = '0;
                wrx_d  = 1'b1;
                word_d = word_asm;
                case (state_q)
                    HEADER: begin
                        case (opcode)
                            8'h00: ;
                            8'h01, 8'h03: begin
                                // Bad channel still consumes its payload word.
                                state_d = (opcode == 8'h01) ? WR_PAYLOAD : RD_PAYLOAD;
                                ch_d    = ch_byte[3:0];
                                ch_ok_d = ch_valid;
                                if (!ch_valid) err_d = 1'b1;
                            end
                            8'h02: begin
                                if (ch_valid) begin
                                    for (int unsigned n = 0; n < NUM_CHANNELS; n++) begin
                                        if (ch_byte[3:0] == 4'(n)) begin
                                            en_d[n]  = ctrl[0];
                                            dir_d[n] = ctrl[1];
                                        end
                                    end
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                            8'h04:   err_d = 1'b0;
                            default: err_d = 1'b1;
                        endcase
                    end
                    WR_PAYLOAD: begin
                        for (int unsigned n = 0; n < NUM_CHANNELS; n++) begin
                            if (ch_ok_q && ch_q == 4'(n)) begin
                                per_d[n*W +: W] = word_asm;
                            end
                        end
                        state_d = HEADER;
                    end
                    default: state_d = HEADER;
                endcase
            end

            // Byte for the next SPI transfer: period byte while reading,
            // otherwise status reflecting the post-byte state and index.
            for (int unsigned n = 0; n < NUM_CHANNELS; n++) begin
                if (ch_ok_d && ch_d == 4'(n)) rd_word = per_q[n*W +: W];
            end
            for (int unsigned k = 0; k < WORD_BYTES; k++) begin
                if (cnt_d == 3'(k)) rd_byte = rd_word[k*8 +: 8];
            end
            if (state_d == RD_PAYLOAD) begin
                send_d = rd_byte;
            end else begin
                send_d = {err_d, 3'b000, 2'(state_d), cnt_d[1:0]};
            end
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q <= HEADER;
            cnt_q   <= '0;
            buf_q   <= '0;
            ch_q    <= '0;
            ch_ok_q <= 1'b0;
            err_q   <= 1'b0;
            en_q    <= '0;
            dir_q   <= '0;
            per_q   <= '0;
            send_q  <= '0;
            wrx_q   <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            ch_q    <= ch_d;
            ch_ok_q <= ch_ok_d;
            err_q   <= err_d;
            en_q    <= en_d;
            dir_q   <= dir_d;
            per_q   <= per_d;
            send_q  <= send_d;
            wrx_q   <= wrx_d;
            word_q  <= word_d;
        end
    end

    assign spi.spi_send_data      = send_q;
    assign spi.word_received      = wrx_q;
    assign spi.word_data_received = word_q;
    assign enable                 = en_q;
    assign direction              = dir_q;
    assign step_period            = per_q;
    assign err                    = err_q;
endmodule

// File: doc/spi_cmd_dispatch.md
SPI_CMD_DISPATCH -- requirements
Module: spi_cmd_dispatch

Interface
REQ-001 Parameter NUM_CHANNELS, default 4, SHALL set the number of stepper channels; legal range 1..16.
REQ-002 Parameter WORD_BYTES, default 4, SHALL set the bytes per little-endian word; legal range 2..8; W = 8*WORD_BYTES.
REQ-003 Port CLK  input  1  SHALL be the single system clock; all state is on its rising edge.
REQ-004 Port resetn  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port SSEL  input  1  SHALL be SPI chip select, active low, already synchronous to CLK.
REQ-006 Port byte_received  input  1  SHALL be a one-CLK pulse marking a valid byte.
REQ-007 Port byte_data_received  input  8  SHALL be the received byte, valid while byte_received is high.
REQ-008 Port spi_send_data  output  8  SHALL be the byte returned on MISO during the next SPI byte.
REQ-009 Port word_received  output  1  SHALL pulse one CLK when a full word is assembled.
REQ-010 Port word_data_received  output  W  SHALL hold the last assembled word.
REQ-011 Port enable  output  NUM_CHANNELS  SHALL give per-channel driver enable.
REQ-012 Port direction  output  NUM_CHANNELS  SHALL give per-channel step direction.
REQ-013 Port step_period  output  NUM_CHANNELS*W  SHALL give per-channel step period; channel n at bits [n*W +: W].
REQ-014 Port err  output  1  SHALL be the sticky command-error flag.

Function
REQ-015 Word assembly SHALL be little endian: first byte of a word -> bits [7:0]; byte counter wraps WORD_BYTES-1 -> 0.
REQ-016 word_received and word_data_received SHALL update on the CLK edge after the byte_received cycle of the last byte (latency 1).
REQ-017 FSM states SHALL be HEADER, WR_PAYLOAD, RD_PAYLOAD; HEADER on reset.
REQ-018 Header word: byte0 = opcode, byte1 = channel index, byte2 = control bits (bit0 enable, bit1 direction), remaining bytes ignored.
REQ-019 Opcode 0x00 NOP SHALL change nothing; stay HEADER.
REQ-020 Opcode 0x01 WRITE_PERIOD SHALL go to WR_PAYLOAD; next word written to step_period[ch] with the word_received pulse; return to HEADER.
REQ-021 Opcode 0x02 SET_CTRL SHALL load enable[ch], direction[ch] from byte2 with the word_received pulse; stay HEADER.
REQ-022 Opcode 0x03 READ_PERIOD SHALL go to RD_PAYLOAD; spi_send_data SHALL present step_period[ch] byte k (LSB first) for payload byte k; return to HEADER after WORD_BYTES bytes.
REQ-023 Opcode 0x04 CLEAR_ERR SHALL clear err; stay HEADER.
REQ-024 Undefined opcode SHALL set err and stay HEADER.
REQ-025 Channel index >= NUM_CHANNELS with opcodes 0x01..0x03 SHALL set err, leave all channel registers unchanged; 0x01/0x03 still consume one payload word (writes discarded, reads return 0x00).
REQ-026 In HEADER and WR_PAYLOAD, spi_send_data SHALL be {err, 3'b000, state_code[1:0], byte_index[1:0]} after each byte; state_code HEADER=0, WR=1, RD=2.
REQ-027 spi_send_data SHALL update on the CLK edge after byte_received so it is stable before the next SPI byte starts.
REQ-028 SSEL high SHALL, on the next CLK edge, return FSM to HEADER, clear byte counter, discard partial word, with no register writes.
REQ-029 byte_received coincident with SSEL high SHALL be dropped.
REQ-030 err set and CLEAR_ERR in the same cycle cannot occur (one opcode per word); err set SHALL otherwise win.

Reset
REQ-031 resetn low SHALL asynchronously clear enable, direction, step_period, err, word_data_received, word_received, spi_send_data to 0, byte counter to 0, FSM to HEADER.
REQ-032 resetn low mid-word or mid-payload SHALL abandon the transaction; first word after release is a header.

Verification
REQ-033 Header {01,02,00,00}, payload {10,27,00,00} -> step_period[2]=0x00002710, word_received pulses twice, err=0.
REQ-034 Header {02,01,03,00} -> enable[1]=1, direction[1]=1, other channels unchanged.
REQ-035 After REQ-033, header {03,02,00,00} then 4 dummy bytes -> MISO bytes 0x10,0x27,0x00,0x00.
REQ-036 Header {01,07,00,00} (NUM_CHANNELS=4) + payload -> err=1, no step_period change; header {04,..} -> err=0.
REQ-037 Two bytes of a header, SSEL high, then full header {02,00,01,00} -> enable[0]=1, no spurious word_received.
REQ-038 resetn low during WR_PAYLOAD byte 2 -> all outputs 0, next word decoded as header.
